// File: rtl/csr_regmap_arbiter_if.sv
// rtl/csr_regmap_arbiter_if.sv - Avalon-MM link bundle for csr_regmap_arbiter (lock signal under CSR_ARB_LOCK_EN)
interface csr_regmap_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

`ifdef CSR_ARB_LOCK_EN
    logic                    lock;

    modport master (
        output addr, byteenable, read, write, writedata, lock,
        input  readdata, readdatavalid, waitrequest
    );
    modport slave (
        input  addr, byteenable, read, write, writedata, lock,
        output readdata, readdatavalid, waitrequest
    );
`else
    modport master (
        output addr, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );
    modport slave (
        input  addr, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
`endif

    // Fixed-latency regmap side: no waitrequest or readdatavalid.
    modport mem_master (
        output addr, byteenable, read, write, writedata,
        input  readdata
    );
    modport mem_slave (
        input  addr, byteenable, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/csr_regmap_arbiter.sv
// rtl/csr_regmap_arbiter.sv - two-port round-robin Avalon-MM arbiter onto the CSR regmap (optional lock: CSR_ARB_LOCK_EN)
module csr_regmap_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                            avms_clk,
    input  logic                            avms_reset,
    csr_regmap_arbiter_if.slave             avms_0,
    csr_regmap_arbiter_if.slave             avms_1,
    csr_regmap_arbiter_if.mem_master        avm
);
    localparam int         BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RD_RET} state_t;

    state_t                  state_q, state_d;
    logic                    grant_q;
    logic                    rr_q;
    logic [1:0]              lat_cnt_q;
    logic                    cmd_write_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q;
    logic [BE_WIDTH-1:0]     cmd_be_q;
    logic [DATA_WIDTH-1:0]   cmd_wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_0_q, rdata_1_q;

    logic req_0, req_1, elig_0, elig_1;
    logic arb_cycle, grant_valid, grant_sel;

    assign req_0     = avms_0.read | avms_0.write;
    assign req_1     = avms_1.read | avms_1.write;
    // RD_RET arbitrates like IDLE so the next grant overlaps the data return.
    assign arb_cycle = (state_q == IDLE) || (state_q == RD_RET);

`ifdef CSR_ARB_LOCK_EN
    logic lock_active_q, lock_port_q;
    assign elig_0 = req_0 && !(lock_active_q && lock_port_q);
    assign elig_1 = req_1 && !(lock_active_q && !lock_port_q);
`else
    assign elig_0 = req_0;
    assign elig_1 = req_1;
`endif

    assign grant_valid = elig_0 | elig_1;
    assign grant_sel   = (elig_0 && elig_1) ? rr_q : elig_1;

    always_comb begin
        state_d               = state_q;
        avm.read              = 1'b0;
        avm.write             = 1'b0;
        avm.addr              = cmd_addr_q;
        avm.byteenable        = cmd_be_q;
        avm.writedata         = cmd_wdata_q;
        avms_0.waitrequest    = 1'b1;
        avms_1.waitrequest    = 1'b1;
        avms_0.readdatavalid  = 1'b0;
        avms_1.readdatavalid  = 1'b0;
        avms_0.readdata       = rdata_0_q;
        avms_1.readdata       = rdata_1_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) state_d = ISSUE;
            end
            ISSUE: begin
                avm.read           = !cmd_write_q;
                avm.write          = cmd_write_q;
                avms_0.waitrequest = grant_q;
                avms_1.waitrequest = !grant_q;
                state_d            = cmd_write_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST) state_d = RD_RET;
            end
            RD_RET: begin
                avms_0.readdatavalid = !grant_q;
                avms_1.readdatavalid = grant_q;
                state_d              = grant_valid ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avms_clk or posedge avms_reset) begin
        if (avms_reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            lat_cnt_q   <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_be_q    <= '0;
            cmd_wdata_q <= '0;
            rdata_0_q   <= '0;
            rdata_1_q   <= '0;
`ifdef CSR_ARB_LOCK_EN
            lock_active_q <= 1'b0;
            lock_port_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (arb_cycle && grant_valid) begin
                grant_q <= grant_sel;
                if (grant_sel) begin
                    cmd_write_q <= avms_1.write;
                    cmd_addr_q  <= avms_1.addr;
                    cmd_be_q    <= avms_1.byteenable;
                    cmd_wdata_q <= avms_1.writedata;
                end else begin
                    cmd_write_q <= avms_0.write;
                    cmd_addr_q  <= avms_0.addr;
                    cmd_be_q    <= avms_0.byteenable;
                    cmd_wdata_q <= avms_0.writedata;
                end
`ifdef CSR_ARB_LOCK_EN
                if (!lock_active_q) rr_q <= ~grant_sel;
`else
                rr_q <= ~grant_sel;
`endif
            end
            if (state_q == ISSUE) begin
                lat_cnt_q <= '0;
            end else if (state_q == RD_WAIT) begin
                lat_cnt_q <= lat_cnt_q + 1'b1;
            end
            // Last RD_WAIT cycle is exactly READ_LATENCY cycles after ISSUE.
            if (state_q == RD_WAIT && lat_cnt_q == LAT_LAST) begin
                if (grant_q) rdata_1_q <= avm.readdata;
                else         rdata_0_q <= avm.readdata;
            end
`ifdef CSR_ARB_LOCK_EN
            if (state_q == ISSUE) begin
                if (grant_q ? avms_1.lock : avms_0.lock) begin
                    lock_active_q <= 1'b1;
                    lock_port_q   <= grant_q;
                end else if (lock_port_q == grant_q) begin
                    lock_active_q <= 1'b0;
                end
            end else if (state_q == IDLE && lock_active_q && !(lock_port_q ? req_1 : req_0)) begin
                lock_active_q <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_csr_regmap_arbiter.sv
// tb/tb_csr_regmap_arbiter.sv - scoreboard bench for csr_regmap_arbiter (lock scenario under CSR_ARB_LOCK_EN)
module tb_csr_regmap_arbiter;
    localparam int RL = 3;

    typedef struct {
        int          port;
        int          cyc;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q_acc[$];
    exp_t q_wr[$];
    exp_t q_rd0[$];
    exp_t q_rd1[$];

    csr_regmap_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) p0 ();
    csr_regmap_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) p1 ();
    csr_regmap_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) mem ();

    csr_regmap_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_LATENCY(RL)) dut (
        .avms_clk   (clk),
        .avms_reset (rst),
        .avms_0     (p0),
        .avms_1     (p1),
        .avm        (mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Regmap model: readdata is valid exactly RL cycles after the read cycle, garbage otherwise.
    logic [31:0] regs [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                              32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    logic [2:0]  pipe_a [RL] = '{default: 3'd0};
    logic        pipe_v [RL] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem.write) begin
            for (int b = 0; b < 4; b++)
                if (mem.byteenable[b]) regs[mem.addr][8*b +: 8] <= mem.writedata[8*b +: 8];
        end
        pipe_v[0] <= mem.read;
        pipe_a[0] <= mem.addr;
        for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign mem.readdata      = pipe_v[RL-1] ? regs[pipe_a[RL-1]] : 32'h0BADF00D;
    assign mem.readdatavalid = 1'b0;
    assign mem.waitrequest   = 1'b0;
`ifdef CSR_ARB_LOCK_EN
    assign mem.lock = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    function automatic void push_acc(input int p, input int c);
        q_acc.push_back('{port: p, cyc: c, addr: 3'd0, data: 32'd0, be: 4'd0});
    endfunction
    function automatic void push_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        q_wr.push_back('{port: 0, cyc: 0, addr: a, data: d, be: be});
    endfunction
    function automatic void push_rd(input int p, input logic [31:0] d, input int c);
        if (p == 0) q_rd0.push_back('{port: 0, cyc: c, addr: 3'd0, data: d, be: 4'd0});
        else        q_rd1.push_back('{port: 1, cyc: c, addr: 3'd0, data: d, be: 4'd0});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT shows an accept, a regmap write or a read strobe.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (!p0.waitrequest || !p1.waitrequest) begin
                chk("acc_exclusive", {31'd0, p0.waitrequest | p1.waitrequest}, 32'd1);
                if (q_acc.size() == 0) unexpected("acc");
                else begin
                    e = q_acc.pop_front();
                    chk("acc_port", p0.waitrequest ? 32'd1 : 32'd0, e.port);
                    chk("acc_cycle", cyc, e.cyc);
                end
            end
            if (mem.read || mem.write) chk("avm_rw_excl", {31'd0, mem.read & mem.write}, 32'd0);
            if (mem.write) begin
                if (q_wr.size() == 0) unexpected("avm_write");
                else begin
                    e = q_wr.pop_front();
                    chk("wr_addr", {29'd0, mem.addr}, {29'd0, e.addr});
                    chk("wr_data", mem.writedata, e.data);
                    chk("wr_be", {28'd0, mem.byteenable}, {28'd0, e.be});
                end
            end
            if (p0.readdatavalid) begin
                if (q_rd0.size() == 0) unexpected("rdv_0");
                else begin
                    e = q_rd0.pop_front();
                    chk("rd0_data", p0.readdata, e.data);
                    chk("rd0_cycle", cyc, e.cyc);
                end
            end
            if (p1.readdatavalid) begin
                if (q_rd1.size() == 0) unexpected("rdv_1");
                else begin
                    e = q_rd1.pop_front();
                    chk("rd1_data", p1.readdata, e.data);
                    chk("rd1_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Requester: holds the command until waitrequest drops, releases it the next cycle.
    task automatic drive(input int p, input bit wr, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        bit done = 1'b0;
        if (p == 0) begin
            p0.addr = a; p0.write = wr; p0.read = !wr; p0.writedata = d; p0.byteenable = be;
        end else begin
            p1.addr = a; p1.write = wr; p1.read = !wr; p1.writedata = d; p1.byteenable = be;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((p == 0 ? p0.waitrequest : p1.waitrequest) == 1'b0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drive_timeout: port %0d got no accept in 50 cycles, required an accept", p);
        end
        @(posedge clk); #1;
        if (p == 0) begin p0.read = 1'b0; p0.write = 1'b0; end
        else        begin p1.read = 1'b0; p1.write = 1'b0; end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_wait0"}, {31'd0, p0.waitrequest}, 32'd1);
        chk({tag, "_wait1"}, {31'd0, p1.waitrequest}, 32'd1);
        chk({tag, "_rdv0"}, {31'd0, p0.readdatavalid}, 32'd0);
        chk({tag, "_rdv1"}, {31'd0, p1.readdatavalid}, 32'd0);
        chk({tag, "_rdata0"}, p0.readdata, 32'd0);
        chk({tag, "_rdata1"}, p1.readdata, 32'd0);
        chk({tag, "_avm_rw"}, {30'd0, mem.read, mem.write}, 32'd0);
        chk({tag, "_avm_addr"}, {29'd0, mem.addr}, 32'd0);
        chk({tag, "_avm_wdata"}, mem.writedata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, m;
        p0.read = 0; p0.write = 0; p0.addr = 0; p0.writedata = 0; p0.byteenable = 0;
        p1.read = 0; p1.write = 0; p1.addr = 0; p1.writedata = 0; p1.byteenable = 0;
`ifdef CSR_ARB_LOCK_EN
        p0.lock = 0; p1.lock = 0;
`endif
        @(posedge clk); #1;
        do_reset("rst0");

        // Single write then read-back on port 0.
        n = cyc;
        push_acc(0, n + 1);
        push_wr(3'd3, 32'hDEADBEEF, 4'hF);
        drive(0, 1, 3'd3, 32'hDEADBEEF, 4'hF);
        m = cyc;
        push_acc(0, m + 1);
        push_rd(0, 32'hDEADBEEF, m + 2 + RL);
        drive(0, 0, 3'd3, 32'd0, 4'hF);
        settle();

        // Collision from reset, then a back-to-back repeat collision that favours port 1.
        do_reset("rst1");
        n = cyc;
        push_acc(0, n + 1); push_acc(1, n + 3); push_acc(0, n + 5); push_acc(1, n + 7);
        push_wr(3'd1, 32'h11, 4'hF); push_wr(3'd1, 32'h22, 4'hF);
        push_wr(3'd1, 32'h33, 4'hF); push_wr(3'd1, 32'h44, 4'hF);
        fork
            begin drive(0, 1, 3'd1, 32'h11, 4'hF); drive(0, 1, 3'd1, 32'h33, 4'hF); end
            begin drive(1, 1, 3'd1, 32'h22, 4'hF); drive(1, 1, 3'd1, 32'h44, 4'hF); end
        join
        m = cyc;
        push_acc(1, m + 1);
        push_rd(1, 32'h44, m + 2 + RL);
        drive(1, 0, 3'd1, 32'd0, 4'hF);
        settle();

        // Continuous reads from both ports: grants alternate with period 2+RL.
        do_reset("rst2");
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            push_acc(k % 2, n + 1 + k * (2 + RL));
            push_rd(k % 2, 32'hC0DE0000 + ((k % 2 == 0) ? 4 + k / 2 : 7 - k / 2), n + (k + 1) * (2 + RL));
        end
        fork
            for (int j = 0; j < 4; j++) drive(0, 0, 3'(4 + j), 32'd0, 4'hF);
            for (int j = 0; j < 4; j++) drive(1, 0, 3'(7 - j), 32'd0, 4'hF);
        join
        settle();

        // Read of addr 5 with a port-1 request arriving during RD_WAIT.
        n = cyc;
        push_acc(0, n + 1);
        push_wr(3'd5, 32'hA5A5A5A5, 4'hF);
        drive(0, 1, 3'd5, 32'hA5A5A5A5, 4'hF);
        m = cyc;
        push_acc(0, m + 1); push_acc(1, m + 3 + RL);
        push_rd(0, 32'hA5A5A5A5, m + 2 + RL);
        push_rd(1, 32'hA5A5A5A5, m + 4 + 2 * RL);
        fork
            drive(0, 0, 3'd5, 32'd0, 4'hF);
            begin repeat (3) @(posedge clk); #1; drive(1, 0, 3'd5, 32'd0, 4'hF); end
        join
        settle();

        // Reset while a read sits in RD_WAIT: no strobe, pointer back to port 0.
        n = cyc;
        push_acc(0, n + 1);
        drive(0, 0, 3'd4, 32'd0, 4'hF);
        @(posedge clk); #1;
        do_reset("rst_midread");
        repeat (RL + 3) @(posedge clk);
        #1;
        n = cyc;
        push_acc(0, n + 1); push_acc(1, n + 3);
        push_wr(3'd0, 32'h55, 4'hF); push_wr(3'd0, 32'h66, 4'hC);
        fork
            drive(0, 1, 3'd0, 32'h55, 4'hF);
            drive(1, 1, 3'd0, 32'h66, 4'hC);
        join
        settle();

`ifdef CSR_ARB_LOCK_EN
        // Locked read-modify-write on port 0 while port 1 keeps requesting.
        do_reset("rst_lock");
        n = cyc;
        push_acc(0, n + 1); push_acc(0, n + 4 + RL); push_acc(1, n + 6 + RL);
        push_rd(0, 32'hC0DE0002, n + 2 + RL);
        push_wr(3'd2, 32'hAB, 4'hF); push_wr(3'd2, 32'h77, 4'hF);
        fork
            begin
                bit seen = 1'b0;
                p0.lock = 1'b1;
                drive(0, 0, 3'd2, 32'd0, 4'hF);
                p0.lock = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (p0.readdatavalid) seen = 1'b1;
                end
                chk("lock_rdv_seen", {31'd0, seen}, 32'd1);
                @(posedge clk); #1;
                drive(0, 1, 3'd2, 32'hAB, 4'hF);
            end
            drive(1, 1, 3'd2, 32'h77, 4'hF);
        join
        settle();
`endif

        chk("left_acc", q_acc.size(), 32'd0);
        chk("left_wr", q_wr.size(), 32'd0);
        chk("left_rd0", q_rd0.size(), 32'd0);
        chk("left_rd1", q_rd1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
